// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM encoding, byte size and START/STOP decode helpers.
package i2c_pkg;

   localparam int unsigned BYTE_BITS = 8;
   localparam int unsigned BIT_CNT_W = 4;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DEV,
      ST_DEV_ACK,
      ST_REG,
      ST_REG_ACK,
      ST_WDATA,
      ST_WACK,
      ST_RDATA,
      ST_RACK
   } i2c_state_e;

   // START: SDA falls while SCL is high on two consecutive samples
   function automatic logic is_start(input logic scl_now, input logic scl_prev,
                                     input logic sda_now, input logic sda_prev);
      return scl_now & scl_prev & sda_prev & ~sda_now;
   endfunction

   function automatic logic is_stop(input logic scl_now, input logic scl_prev,
                                    input logic sda_now, input logic sda_prev);
      return scl_now & scl_prev & ~sda_prev & sda_now;
   endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain and decodes SCL edges plus START/STOP conditions.
module i2c_bus_sync
   import i2c_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_s_o,
   output logic scl_rise_c,
   output logic scl_fall_c,
   output logic start_c,
   output logic stop_c
);

   // [0],[1] synchroniser stages, [2] previous sample for edge detection
   logic [2:0] scl_q;
   logic [2:0] sda_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_q <= '1;
         sda_q <= '1;
      end else begin
         scl_q <= {scl_q[1:0], scl_i};
         sda_q <= {sda_q[1:0], sda_i};
      end
   end

   assign sda_s_o    = sda_q[1];
   assign scl_rise_c = scl_q[1] & ~scl_q[2];
   assign scl_fall_c = ~scl_q[1] & scl_q[2];
   assign start_c    = is_start(scl_q[1], scl_q[2], sda_q[1], sda_q[2]);
   assign stop_c     = is_stop(scl_q[1], scl_q[2], sda_q[1], sda_q[2]);

endmodule

// File: rtl/i2c_slave_burst.sv
// I2C target with a MEM_DEPTH x 8 register file, auto-incrementing burst reads/writes
// and a local readback port.
module i2c_slave_burst
   import i2c_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR  = 7'd1,
   parameter int unsigned MEM_DEPTH = 32,
   parameter int unsigned AW        = 5,
   parameter bit          AUTO_INC  = 1'b1,
   parameter bit          WRAP      = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          scl,
   input  logic          sda_o,
   output logic          sda_i,
   output logic          sda_t,
   input  logic [AW-1:0] dbg_addr,
   output logic [7:0]    dbg_data,
   output logic          wr_stb,
   output logic [AW-1:0] wr_addr,
   output logic          busy
);

   localparam logic [AW-1:0]        LAST_PTR = AW'(MEM_DEPTH - 1);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BYTE_BITS - 1);
   localparam logic [BIT_CNT_W-1:0] ALL_BITS = BIT_CNT_W'(BYTE_BITS);

   logic sda_s, scl_rise_c, scl_fall_c, start_c, stop_c;

   i2c_bus_sync u_sync (
      .clk        (clk),
      .rst        (rst),
      .scl_i      (scl),
      .sda_i      (sda_o),
      .sda_s_o    (sda_s),
      .scl_rise_c (scl_rise_c),
      .scl_fall_c (scl_fall_c),
      .start_c    (start_c),
      .stop_c     (stop_c)
   );

   i2c_state_e           state_q, state_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [7:0]           shift_q, shift_d;
   logic [AW-1:0]        ptr_q, ptr_d;
   logic                 sat_q, sat_d;
   logic                 rw_q, rw_d;
   logic                 ack_ph_q, ack_ph_d;
   logic                 ack_ok_q, ack_ok_d;
   logic                 wr_pend_q, wr_pend_d;
   logic                 sda_t_q, sda_t_d;
   logic                 wr_stb_q, wr_stb_d;
   logic [AW-1:0]        wr_addr_q, wr_addr_d;
   logic                 busy_q, busy_d;
   logic [7:0]           dbg_data_q, dbg_data_d;
   logic [7:0]           mem_q [MEM_DEPTH];
   logic                 we_c;

   logic [7:0]    byte_c, rd_cur_c, rd_next_c;
   logic [AW-1:0] ptr_adv_c;
   logic          sat_adv_c;

   // Pointer advance: modulo MEM_DEPTH with WRAP, otherwise sticks at the end and flags saturation
   always_comb begin
      ptr_adv_c = ptr_q;
      sat_adv_c = sat_q;
      if (AUTO_INC && !sat_q) begin
         if (ptr_q == LAST_PTR) begin
            if (WRAP) ptr_adv_c = '0;
            else      sat_adv_c = 1'b1;
         end else begin
            ptr_adv_c = ptr_q + AW'(1);
         end
      end
   end

   assign byte_c    = {shift_q[6:0], sda_s};
   assign rd_cur_c  = sat_q ? 8'hFF : mem_q[ptr_q];
   assign rd_next_c = sat_adv_c ? 8'hFF : mem_q[ptr_adv_c];

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      ptr_d      = ptr_q;
      sat_d      = sat_q;
      rw_d       = rw_q;
      ack_ph_d   = ack_ph_q;
      ack_ok_d   = ack_ok_q;
      wr_pend_d  = 1'b0;
      sda_t_d    = sda_t_q;
      wr_stb_d   = 1'b0;
      wr_addr_d  = wr_addr_q;
      busy_d     = busy_q;
      we_c       = 1'b0;
      dbg_data_d = (32'(dbg_addr) < MEM_DEPTH) ? mem_q[dbg_addr] : 8'h00;

      // Commit the byte one clk after its 8th bit; a saturated pointer discards it and NACKs
      if (wr_pend_q) begin
         ack_ok_d = ~sat_q;
         if (!sat_q) begin
            we_c      = 1'b1;
            wr_stb_d  = 1'b1;
            wr_addr_d = ptr_q;
         end
      end

      if (stop_c) begin
         state_d = ST_IDLE;
         sda_t_d = 1'b1;
         busy_d  = 1'b0;
      end else if (start_c) begin
         state_d   = ST_DEV;
         bit_cnt_d = '0;
         sda_t_d   = 1'b1;
      end else begin
         case (state_q)
            ST_DEV, ST_REG, ST_WDATA: begin
               if (scl_rise_c) begin
                  shift_d   = byte_c;
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                  if (bit_cnt_q == LAST_BIT) begin
                     ack_ph_d = 1'b0;
                     if (state_q == ST_DEV) begin
                        if (shift_q[6:0] == DEV_ADDR) begin
                           state_d = ST_DEV_ACK;
                           rw_d    = sda_s;
                           busy_d  = 1'b1;
                        end else begin
                           state_d = ST_IDLE;
                           busy_d  = 1'b0;
                        end
                     end else if (state_q == ST_REG) begin
                        if ({1'b0, byte_c} < 9'(MEM_DEPTH)) begin
                           ptr_d   = byte_c[AW-1:0];
                           sat_d   = 1'b0;
                           state_d = ST_REG_ACK;
                        end else begin
                           state_d = ST_IDLE;
                        end
                     end else begin
                        state_d   = ST_WACK;
                        wr_pend_d = 1'b1;
                     end
                  end
               end
            end
            // First SCL fall drives the ACK slot, second fall ends it and moves on
            ST_DEV_ACK, ST_REG_ACK, ST_WACK: begin
               if (scl_fall_c) begin
                  if (!ack_ph_q) begin
                     ack_ph_d = 1'b1;
                     sda_t_d  = (state_q == ST_WACK) ? ~ack_ok_q : 1'b0;
                  end else begin
                     ack_ph_d  = 1'b0;
                     bit_cnt_d = '0;
                     sda_t_d   = 1'b1;
                     if (state_q == ST_DEV_ACK) begin
                        state_d = ST_REG;
                     end else if (state_q == ST_WACK) begin
                        state_d = ST_WDATA;
                        ptr_d   = ptr_adv_c;
                        sat_d   = sat_adv_c;
                     end else if (rw_q) begin
                        state_d = ST_WDATA;
                     end else begin
                        state_d = ST_RDATA;
                        sda_t_d = rd_cur_c[7];
                        shift_d = {rd_cur_c[6:0], 1'b0};
                     end
                  end
               end
            end
            ST_RDATA: begin
               if (scl_rise_c) begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end else if (scl_fall_c) begin
                  if (bit_cnt_q == ALL_BITS) begin
                     sda_t_d = 1'b1;
                     state_d = ST_RACK;
                  end else begin
                     sda_t_d = shift_q[7];
                     shift_d = {shift_q[6:0], 1'b0};
                  end
               end
            end
            ST_RACK: begin
               if (scl_rise_c && sda_s) begin
                  state_d = ST_IDLE;
               end else if (scl_fall_c) begin
                  ptr_d     = ptr_adv_c;
                  sat_d     = sat_adv_c;
                  sda_t_d   = rd_next_c[7];
                  shift_d   = {rd_next_c[6:0], 1'b0};
                  bit_cnt_d = '0;
                  state_d   = ST_RDATA;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         ptr_q      <= '0;
         sat_q      <= 1'b0;
         rw_q       <= 1'b0;
         ack_ph_q   <= 1'b0;
         ack_ok_q   <= 1'b0;
         wr_pend_q  <= 1'b0;
         sda_t_q    <= 1'b1;
         wr_stb_q   <= 1'b0;
         wr_addr_q  <= '0;
         busy_q     <= 1'b0;
         dbg_data_q <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         ptr_q      <= ptr_d;
         sat_q      <= sat_d;
         rw_q       <= rw_d;
         ack_ph_q   <= ack_ph_d;
         ack_ok_q   <= ack_ok_d;
         wr_pend_q  <= wr_pend_d;
         sda_t_q    <= sda_t_d;
         wr_stb_q   <= wr_stb_d;
         wr_addr_q  <= wr_addr_d;
         busy_q     <= busy_d;
         dbg_data_q <= dbg_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
      end else if (we_c) begin
         mem_q[ptr_q] <= shift_q;
      end
   end

   assign sda_i    = 1'b0;
   assign sda_t    = sda_t_q;
   assign dbg_data = dbg_data_q;
   assign wr_stb   = wr_stb_q;
   assign wr_addr  = wr_addr_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_burst.sv
// Directed bench: bit-banged I2C master driving three targets on one wired-AND SDA line.
module tb_i2c_slave_burst;

   localparam int P = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, scl, m_sda;
   logic sda_bus;

   logic       s1_sda_i, s1_sda_t, s1_stb, s1_busy;
   logic [4:0] s1_dbg_addr, s1_wr_addr;
   logic [7:0] s1_dbg;
   logic       s2_sda_i, s2_sda_t, s2_stb, s2_busy;
   logic [4:0] s2_dbg_addr, s2_wr_addr;
   logic [7:0] s2_dbg;
   logic       s3_sda_i, s3_sda_t, s3_stb, s3_busy;
   logic [4:0] s3_dbg_addr, s3_wr_addr;
   logic [7:0] s3_dbg;

   assign sda_bus = m_sda & (s1_sda_t | s1_sda_i) & (s2_sda_t | s2_sda_i) & (s3_sda_t | s3_sda_i);

   i2c_slave_burst #(.DEV_ADDR(7'd1)) u_s1 (
      .clk(clk), .rst(rst), .scl(scl), .sda_o(sda_bus), .sda_i(s1_sda_i), .sda_t(s1_sda_t),
      .dbg_addr(s1_dbg_addr), .dbg_data(s1_dbg), .wr_stb(s1_stb), .wr_addr(s1_wr_addr), .busy(s1_busy));

   i2c_slave_burst #(.DEV_ADDR(7'd2)) u_s2 (
      .clk(clk), .rst(rst), .scl(scl), .sda_o(sda_bus), .sda_i(s2_sda_i), .sda_t(s2_sda_t),
      .dbg_addr(s2_dbg_addr), .dbg_data(s2_dbg), .wr_stb(s2_stb), .wr_addr(s2_wr_addr), .busy(s2_busy));

   i2c_slave_burst #(.DEV_ADDR(7'd3), .WRAP(1'b0)) u_s3 (
      .clk(clk), .rst(rst), .scl(scl), .sda_o(sda_bus), .sda_i(s3_sda_i), .sda_t(s3_sda_t),
      .dbg_addr(s3_dbg_addr), .dbg_data(s3_dbg), .wr_stb(s3_stb), .wr_addr(s3_wr_addr), .busy(s3_busy));

   int         n_run = 0, n_fail = 0;
   int         s1_stb_n = 0, s2_stb_n = 0, s3_stb_n = 0;
   logic [4:0] s1_last = '0;
   logic       s1_watch = 1'b0, s1_drove = 1'b0;

   always @(posedge clk) begin
      if (s1_stb) begin s1_stb_n++; s1_last = s1_wr_addr; end
      if (s2_stb) s2_stb_n++;
      if (s3_stb) s3_stb_n++;
      if (s1_watch && !s1_sda_t) s1_drove = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; clks(P); scl = 1'b1; clks(P); m_sda = 1'b0; clks(P); scl = 1'b0; clks(2);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; clks(P); scl = 1'b1; clks(P); m_sda = 1'b1; clks(P);
   endtask

   task automatic put_bit(input logic b);
      m_sda = b; clks(P); scl = 1'b1; clks(P); scl = 1'b0; clks(2);
   endtask

   task automatic get_bit(output logic b);
      m_sda = 1'b1; clks(P); scl = 1'b1; clks(P/2); b = sda_bus; clks(P/2); scl = 1'b0; clks(2);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) put_bit(d[i]);
      get_bit(ack);
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin get_bit(b); d[i] = b; end
      put_bit(nack);
   endtask

   task automatic chk_mem(input string tag, input int which, input logic [4:0] a, input logic [7:0] exp);
      s1_dbg_addr = a; s2_dbg_addr = a; s3_dbg_addr = a;
      clks(2);
      case (which)
         1:       check(tag, 32'(s1_dbg), 32'(exp));
         2:       check(tag, 32'(s2_dbg), 32'(exp));
         default: check(tag, 32'(s3_dbg), 32'(exp));
      endcase
   endtask

   logic a0, a1, a2, a3, a4;
   logic [7:0] d0, d1, d2;

   initial begin
      rst = 1'b1; scl = 1'b1; m_sda = 1'b1;
      s1_dbg_addr = '0; s2_dbg_addr = '0; s3_dbg_addr = '0;
      clks(4); rst = 1'b0; clks(2);

      check("rst_sda_t", 32'(s1_sda_t), 32'd1);
      check("rst_sda_i", 32'(s1_sda_i), 32'd0);
      check("rst_wr_stb", 32'(s1_stb), 32'd0);
      check("rst_wr_addr", 32'(s1_wr_addr), 32'd0);
      check("rst_busy", 32'(s1_busy), 32'd0);
      check("rst_dbg", 32'(s1_dbg), 32'd0);

      // single write reg 3 <= 33
      i2c_start();
      write_byte(8'h03, a0);
      check("wr1_busy", 32'(s1_busy), 32'd1);
      write_byte(8'h03, a1);
      write_byte(8'h33, a2);
      i2c_stop();
      check("wr1_acks", 32'({a0, a1, a2}), 32'd0);
      check("wr1_busy_after_stop", 32'(s1_busy), 32'd0);
      check("wr1_stb_n", 32'(s1_stb_n), 32'd1);
      check("wr1_addr", 32'(s1_last), 32'd3);
      chk_mem("wr1_mem3", 1, 5'd3, 8'h33);

      // burst write with wrap 30,31,0
      i2c_start();
      write_byte(8'h03, a0); write_byte(8'd30, a1);
      write_byte(8'hA0, a2); write_byte(8'hA1, a3); write_byte(8'hA2, a4);
      i2c_stop();
      check("wrap_acks", 32'({a0, a1, a2, a3, a4}), 32'd0);
      check("wrap_stb_n", 32'(s1_stb_n), 32'd4);
      chk_mem("wrap_mem30", 1, 5'd30, 8'hA0);
      chk_mem("wrap_mem31", 1, 5'd31, 8'hA1);
      chk_mem("wrap_mem0", 1, 5'd0, 8'hA2);

      // preload 4..6 then burst read with ACK,ACK,NACK
      i2c_start();
      write_byte(8'h03, a0); write_byte(8'h04, a1);
      write_byte(8'h44, a2); write_byte(8'h55, a3); write_byte(8'h66, a4);
      i2c_stop();
      check("pre_acks", 32'({a0, a1, a2, a3, a4}), 32'd0);
      i2c_start();
      write_byte(8'h02, a0); write_byte(8'h04, a1);
      read_byte(1'b0, d0); read_byte(1'b0, d1); read_byte(1'b1, d2);
      check("rd_acks", 32'({a0, a1}), 32'd0);
      check("rd_byte0", 32'(d0), 32'h44);
      check("rd_byte1", 32'(d1), 32'h55);
      check("rd_byte2", 32'(d2), 32'h66);
      check("rd_released", 32'(s1_sda_t), 32'd1);
      i2c_stop();
      check("rd_stb_n", 32'(s1_stb_n), 32'd7);

      // frame to address 2: only slave 2 responds
      s1_drove = 1'b0; s1_watch = 1'b1;
      i2c_start();
      write_byte(8'h05, a0); write_byte(8'h01, a1); write_byte(8'hBB, a2);
      i2c_stop();
      s1_watch = 1'b0;
      check("flt_acks", 32'({a0, a1, a2}), 32'd0);
      check("flt_s1_quiet", 32'(s1_drove), 32'd0);
      check("flt_s2_stb_n", 32'(s2_stb_n), 32'd1);
      check("flt_s1_stb_n", 32'(s1_stb_n), 32'd7);
      chk_mem("flt_s2_mem1", 2, 5'd1, 8'hBB);
      chk_mem("flt_s1_mem1", 1, 5'd1, 8'h00);

      // out-of-range register address
      i2c_start();
      write_byte(8'h03, a0); write_byte(8'd40, a1);
      i2c_stop();
      check("oor_dev_ack", 32'(a0), 32'd0);
      check("oor_reg_nack", 32'(a1), 32'd1);

      // WRAP=0 saturation on slave 3
      i2c_start();
      write_byte(8'h07, a0); write_byte(8'd31, a1); write_byte(8'h11, a2); write_byte(8'h22, a3);
      i2c_stop();
      check("sat_acks", 32'({a0, a1, a2}), 32'd0);
      check("sat_nack", 32'(a3), 32'd1);
      check("sat_stb_n", 32'(s3_stb_n), 32'd1);
      chk_mem("sat_mem31", 3, 5'd31, 8'h11);
      chk_mem("sat_mem0", 3, 5'd0, 8'h00);
      i2c_start();
      write_byte(8'h06, a0); write_byte(8'd31, a1);
      read_byte(1'b0, d0); read_byte(1'b1, d1);
      i2c_stop();
      check("sat_rd0", 32'(d0), 32'h11);
      check("sat_rd1", 32'(d1), 32'hFF);

      // reset during WDATA bit 4
      i2c_start();
      write_byte(8'h03, a0); write_byte(8'h0A, a1);
      for (int i = 0; i < 4; i++) put_bit(1'b1);
      rst = 1'b1; clks(1); rst = 1'b0;
      check("mrst_sda_t", 32'(s1_sda_t), 32'd1);
      i2c_stop();
      check("mrst_stb_n", 32'(s1_stb_n), 32'd7);
      chk_mem("mrst_mem10", 1, 5'd10, 8'h00);
      chk_mem("mrst_mem3_cleared", 1, 5'd3, 8'h00);

      // reset while the address ACK is being driven
      i2c_start();
      for (int i = 7; i >= 0; i--) put_bit(i < 2);
      clks(6);
      check("ackrst_driving", 32'(s1_sda_t), 32'd0);
      rst = 1'b1; clks(1); rst = 1'b0;
      check("ackrst_released", 32'(s1_sda_t), 32'd1);
      i2c_stop();

      // repeated START after REG_ACK
      i2c_start();
      write_byte(8'h03, a0); write_byte(8'h07, a1);
      i2c_start();
      write_byte(8'h03, a2); write_byte(8'h08, a3); write_byte(8'h88, a4);
      i2c_stop();
      check("rs_acks", 32'({a0, a1, a2, a3, a4}), 32'd0);
      check("rs_stb_n", 32'(s1_stb_n), 32'd8);
      check("rs_addr", 32'(s1_last), 32'd8);
      chk_mem("rs_mem8", 1, 5'd8, 8'h88);
      chk_mem("rs_mem7", 1, 5'd7, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_slave_burst.md
Name: i2c_slave_burst

Overview:
- Parametrised successor of the single-byte I2C slave: an I2C target with a register file of configurable depth, a configurable device address, and burst (auto-incrementing) multi-byte reads and writes.
- It supports repeated START, NACKs out-of-range register addresses, and exposes a local readback port and write strobe for the fabric side.
- It sits on the shared SDA/SCL bus beside the i2c_master and other slaves, connected through tristate_BUF.

Parameters:
- DEV_ADDR, 7'd1, 7-bit device address matched on the bus.
- MEM_DEPTH, 32, number of 8-bit registers, 2..256.
- AW, 5, register address width, = clog2(MEM_DEPTH).
- AUTO_INC, 1, 1 = register pointer increments after every data byte; 0 = pointer fixed for the whole frame.
- WRAP, 1, 1 = pointer wraps MEM_DEPTH-1 -> 0; 0 = pointer saturates and later bytes are NACKed (write) or return 8'hFF (read).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- scl  in  1  bus SCL, asynchronous to clk.
- sda_o  in  1  SDA pad value, from buffer O.
- sda_i  out  1  SDA drive value, to buffer I; constant 0.
- sda_t  out  1  SDA tristate control; 1 = released (high-Z), 0 = drive low.
- dbg_addr  in  AW  local readback address.
- dbg_data  out  8  mem[dbg_addr], registered, 1-cycle latency.
- wr_stb  out  1  1-cycle pulse on each register write.
- wr_addr  out  AW  address of the register written, valid with wr_stb.
- busy  out  1  high from an addressed START until STOP or mismatch.

Behaviour:
- Reset: state=IDLE, sda_t=1, sda_i=0, wr_stb=0, wr_addr=0, busy=0, dbg_data=0, pointer=0, all mem=8'h00. A reset mid-frame aborts the frame and releases SDA immediately, with no partial write.
- Sync and edge detect:
  - scl and sda_o each pass through a 2-FF synchroniser, then a 3rd FF for edge detection.
  - START = SDA fall while SCL high. STOP = SDA rise while SCL high.
  - Bits are sampled on the detected SCL rise. SDA is changed only on the detected SCL fall.
  - Requires SCL high/low phases >= 4 clk.
- Frame format (codebase convention, R/W bit 1 = write, 0 = read): START, ADDR[6:0]+RW, ACK, REGADDR byte (low AW bits used), ACK, then data bytes.
- FSM states: IDLE, DEV, DEV_ACK, REG, REG_ACK, WDATA, WACK, RDATA, RACK.
  - IDLE -> DEV on START, bit counter cleared.
  - DEV: shift 8 bits.
    - If address == DEV_ADDR -> DEV_ACK.
    - Otherwise -> IDLE, SDA stays released for the whole frame.
  - DEV_ACK: drive SDA low for one SCL period -> REG.
  - REG: shift 8 bits.
    - If value < MEM_DEPTH: load pointer -> REG_ACK (ACK).
    - Otherwise: NACK (SDA released through the ACK slot) -> IDLE.
  - REG_ACK -> WDATA if RW=1, or RDATA if RW=0. RDATA preloads mem[pointer] into the shift register.
  - WDATA: 8 bits sampled, then write mem[pointer] and pulse wr_stb on the 8th SCL rise + 1 clk -> WACK (ACK), then advance the pointer per AUTO_INC/WRAP -> WDATA.
  - RDATA: drive MSB-first. sda_t = shift bit (1 releases). After the 8th bit release SDA -> RACK.
  - RACK: sample the master bit on SCL rise.
    - 0 (ACK): advance pointer, load next byte -> RDATA.
    - 1 (NACK): -> IDLE.
- STOP in any state -> IDLE, release SDA, busy=0.
- Repeated START in any state -> DEV, keeping the pointer. A repeated-START frame still resends REGADDR.
- Saturation with WRAP=0: after writing MEM_DEPTH-1, further write bytes get NACK and are discarded. Reads return 8'hFF.
- Simultaneous local readback and bus write to the same address: dbg_data shows the old value that cycle and the new value the next cycle.
- Bytes are 8 bits. Pointer arithmetic is modulo MEM_DEPTH (not modulo 2^AW) when MEM_DEPTH is not a power of 2.

Decomposition:
- Package i2c_pkg: FSM state encoding, bit-count constant (8), START/STOP detect macros, shared by master and slaves.
- One sub-module, i2c_bus_sync: synchronisers plus scl_rise/scl_fall/start/stop pulse generation, reusable by i2c_master.
- The register file stays inline.

Test Plan:
- Single write: DEV_ADDR=1, frame addr 1/RW=1, reg 3, data 8'h33, STOP -> three ACKs, wr_stb once with wr_addr=3, dbg_data(3)=8'h33.
- Burst write with wrap: reg 30, data 8'hA0,8'hA1,8'hA2, MEM_DEPTH=32 -> mem[30]=A0, mem[31]=A1, mem[0]=A2, three wr_stb pulses.
- Burst read: preload mem[4..6]=44,55,66; frame RW=0, reg 4, master ACK,ACK,NACK -> SDA carries 8'h44,8'h55,8'h66, then slave returns to IDLE.
- Address filtering: two instances (DEV_ADDR=1, 2); frame to address 2, reg 1, data 8'hBB -> only slave 2 ACKs and writes; slave 1 sda_t stays 1 throughout.
- Error cases: reg 40 with MEM_DEPTH=32 -> NACK in the REGADDR slot. WRAP=0 write at reg 31 with two bytes -> ACK then NACK, mem[0] unchanged.
- Mid-frame events: rst asserted during WDATA bit 4 -> sda_t=1 next clk, target byte unchanged. Repeated START after a REG_ACK -> new frame accepted normally.
